// File: rtl/pool_pkg.sv
// Shared types and constants for the average-pooling sequencer.
// Mode encoding, lane geometry, FSM state enum and ring-index helper.
package pool_pkg;

    localparam int ROW_W   = 18;
    localparam int PIX_W   = 10;
    localparam int RES_W   = 17;
    localparam int N_LANES = 16;

    localparam logic POOL_3X3 = 1'b1;
    localparam logic POOL_2X2 = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } pool_state_t;

    function automatic logic [1:0] ring_next(input logic [1:0] r);
        return (r == 2'd2) ? 2'd0 : r + 2'd1;
    endfunction

endpackage

// File: rtl/line_ring3.sv
// Three-row ring line buffer: one pixel write per cycle, rotated combinational read.
// Read port places the row at index rd_old in slot 0 and the newest row in slot 2.
module line_ring3
    import pool_pkg::*;
(
    input  logic                          clk,
    input  logic                          we,
    input  logic [1:0]                    wr_row,
    input  logic [$clog2(ROW_W)-1:0]      wr_col,
    input  logic [PIX_W-1:0]              wr_dat,
    input  logic [1:0]                    rd_old,
    output logic [3*ROW_W*PIX_W-1:0]      rd_rows
);

    localparam int RW = ROW_W * PIX_W;

    logic [RW-1:0] row0;
    logic [RW-1:0] row1;
    logic [RW-1:0] row2;
    logic [1:0]    idx;

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            case (wr_row)
                2'd0:    row0[int'(wr_col) * PIX_W +: PIX_W] <= wr_dat;
                2'd1:    row1[int'(wr_col) * PIX_W +: PIX_W] <= wr_dat;
                2'd2:    row2[int'(wr_col) * PIX_W +: PIX_W] <= wr_dat;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_rows = '0;
        idx     = rd_old;
        for (int k = 0; k < 3; k++) begin
            case (idx)
                2'd0:    rd_rows[k*RW +: RW] = row0;
                2'd1:    rd_rows[k*RW +: RW] = row1;
                2'd2:    rd_rows[k*RW +: RW] = row2;
                default: rd_rows[k*RW +: RW] = '0;
            endcase
            idx = ring_next(idx);
        end
    end

endmodule

// File: rtl/pool_sequencer.sv
// Frame controller for the pooling datapath: fills a 3-row ring, issues windows, returns results.
// pool_go one cycle after the closing pixel, res_valid POOL_LAT+1 later; pix_ready low outside FILL.
module pool_sequencer
    import pool_pkg::*;
#(
    parameter int FRAME_H  = 18,
    parameter int POOL_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          size_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [PIX_W-1:0]              pix_data,
    output logic [3*ROW_W*PIX_W-1:0]      pool_rows,
    output logic                          pool_size,
    output logic                          pool_go,
    input  logic [N_LANES*RES_W-1:0]      pool_res,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [N_LANES*RES_W-1:0]      res_data,
    output logic                          res_last,
    output logic                          busy,
    output logic                          done
);

    localparam int RW = ROW_W * PIX_W;
    localparam int CW = $clog2(FRAME_H + 1);
    localparam int LW = $clog2(POOL_LAT + 1);
    localparam int XW = $clog2(ROW_W);

    localparam logic [CW-1:0] FH       = CW'(FRAME_H);
    localparam logic [CW-1:0] NWIN_3X3 = CW'(FRAME_H - 2);
    localparam logic [CW-1:0] NWIN_2X2 = CW'(FRAME_H / 2);
    localparam logic [XW-1:0] COL_LAST = XW'(ROW_W - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(POOL_LAT - 1);

    pool_state_t    state;
    pool_state_t    state_nx;

    logic [XW-1:0]  col;
    logic [CW-1:0]  rows_rx;
    logic [CW-1:0]  win_cnt;
    logic [1:0]     wr_row;
    logic [LW-1:0]  lat_cnt;
    logic           last_q;
    logic           done_q;

    logic           pix_acc;
    logic           row_wrap;
    logic [CW-1:0]  rows_nx;
    logic           win_cond;
    logic           frame_end;
    logic           lat_end;
    logic [1:0]     wr_row_nx;
    logic [CW-1:0]  n_win;
    logic [3*RW-1:0] ring_rd;
    logic [3*RW-1:0] win_rows;

    assign pix_acc   = pix_valid && pix_ready;
    assign row_wrap  = pix_acc && (col == COL_LAST);
    assign rows_nx   = rows_rx + CW'(1);
    assign wr_row_nx = ring_next(wr_row);
    assign lat_end   = (lat_cnt == LAT_LAST);
    assign n_win     = (pool_size == POOL_3X3) ? NWIN_3X3 : NWIN_2X2;
    assign win_cond  = (pool_size == POOL_2X2) ? !rows_nx[0] : (rows_nx >= CW'(3));
    // An odd 2x2 frame ends on a row wrap that yields no window.
    assign frame_end = (row_wrap && !win_cond && (rows_nx == FH)) ||
                       ((state == ST_OUT) && res_ready && (rows_rx == FH));

    line_ring3 u_ring (
        .clk     (clk),
        .we      (pix_acc),
        .wr_row  (wr_row),
        .wr_col  (col),
        .wr_dat  (pix_data),
        .rd_old  (wr_row_nx),
        .rd_rows (ring_rd)
    );

    // The closing pixel lands in the ring on this same edge, so it is spliced in here.
    always_comb begin
        win_rows = ring_rd;
        win_rows[2*RW + (ROW_W-1)*PIX_W +: PIX_W] = pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FILL;
            ST_FILL: begin
                if (row_wrap) begin
                    if (win_cond)            state_nx = ST_ISSUE;
                    else if (rows_nx == FH)  state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (lat_end) state_nx = ST_OUT;
            ST_OUT:   if (res_ready) state_nx = (rows_rx == FH) ? ST_IDLE : ST_FILL;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready = (state == ST_FILL);
        pool_go   = (state == ST_ISSUE);
        res_valid = (state == ST_OUT);
        res_last  = (state == ST_OUT) && last_q;
        busy      = (state != ST_IDLE);
        done      = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_size <= 1'b0;
            pool_rows <= '0;
            res_data  <= '0;
            col       <= '0;
            rows_rx   <= '0;
            win_cnt   <= '0;
            wr_row    <= 2'd0;
            lat_cnt   <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= frame_end;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pool_size <= size_in;
                        col       <= '0;
                        rows_rx   <= '0;
                        win_cnt   <= '0;
                        wr_row    <= 2'd0;
                    end
                end
                ST_FILL: begin
                    if (pix_acc) begin
                        col <= row_wrap ? '0 : col + XW'(1);
                        if (row_wrap) begin
                            rows_rx <= rows_nx;
                            wr_row  <= wr_row_nx;
                            if (win_cond) begin
                                pool_rows <= win_rows;
                                win_cnt   <= win_cnt + CW'(1);
                                last_q    <= ((win_cnt + CW'(1)) == n_win);
                            end
                        end
                    end
                end
                ST_ISSUE: lat_cnt <= '0;
                ST_WAIT: begin
                    lat_cnt <= lat_cnt + LW'(1);
                    if (lat_end) res_data <= pool_res;
                end
                default: ;
            endcase
        end
    end

endmodule
